program_loader: RTL and testbench

Writes a program image into the instruction memory so that a new program runs without re-synthesizing the memory init file. A byte stream arrives over a valid/ready interface: a 16-bit word-count header, then big-endian instruction words. The block assembles each word and issues one write per word to the program memory write port, starting at the MIPS text base address. It holds the processor in reset (`cpu_hold`) while loading.

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 108 ++++++++++
 tb/tb_program_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port shared by the loader and its host.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, write_enable, write_address, write_data, cpu_hold, done, error
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, write_enable, write_address, write_data, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Loads a word-count header plus big-endian instruction words into program memory.
// 5 cycles per word on an unstalled stream; byte_ready is low outside header/data collection.
module program_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [31:0]           DEPTH_LIMIT = 32'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ADDR_STEP   = DATA_WIDTH'(4);

  logic [2:0]            state;
  logic [7:0]            n_hi;
  logic [15:0]           n_words;
  logic [15:0]           word_index;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic        ready;
  logic        accept;
  logic [15:0] hdr_n;
  logic [15:0] next_index;
  logic [4:0]  lane_lsb;

  assign ready      = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA);
  assign accept     = bus.byte_valid && ready;
  assign hdr_n      = {n_hi, bus.byte_data};
  assign next_index = word_index + 16'd1;
  // First byte of a word lands in the top lane.
  assign lane_lsb   = {~byte_cnt, 3'b000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      n_hi       <= 8'd0;
      n_words    <= 16'd0;
      word_index <= 16'd0;
      byte_cnt   <= 2'd0;
      addr_q     <= BASE_ADDRESS;
      data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          word_index <= 16'd0;
          byte_cnt   <= 2'd0;
          addr_q     <= BASE_ADDRESS;
          if (bus.start) state <= S_HDR_HI;
        end
        S_HDR_HI: begin
          if (accept) begin
            n_hi  <= bus.byte_data;
            state <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            n_words <= hdr_n;
            if (hdr_n == 16'd0)                   state <= S_DONE;
            else if ({16'd0, hdr_n} > DEPTH_LIMIT) state <= S_ERROR;
            else                                  state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            data_q[lane_lsb +: 8] <= bus.byte_data;
            byte_cnt              <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_index <= next_index;
          addr_q     <= addr_q + ADDR_STEP;
          state      <= (next_index == n_words) ? S_DONE : S_DATA;
        end
        S_DONE: state <= S_IDLE;
        S_ERROR: begin
          if (bus.start) begin
            word_index <= 16'd0;
            byte_cnt   <= 2'd0;
            addr_q     <= BASE_ADDRESS;
            state      <= S_HDR_HI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready    = ready;
  assign bus.write_enable  = (state == S_WRITE);
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
  assign bus.cpu_hold      = (state != S_IDLE) && (state != S_ERROR);
  assign bus.done          = (state == S_DONE);
  assign bus.error         = (state == S_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a byte-stream level reference model checked every cycle.
module tb_program_loader;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  program_loader_if #(.DATA_WIDTH(32)) bus ();

  program_loader #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: tracks the bytes accepted in the current load and derives writes from them.
  bit          m_loading = 0;
  bit          m_wr      = 0;
  bit          m_done    = 0;
  bit          m_err     = 0;
  logic [7:0]  m_got[$];
  int          m_n       = 0;
  int          m_words   = 0;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_byte_ready", bus.byte_ready, 0);
      chk("rst_write_enable", bus.write_enable, 0);
      chk("rst_write_address", bus.write_address, BASE);
      chk("rst_write_data", bus.write_data, 0);
      chk("rst_cpu_hold", bus.cpu_hold, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      m_loading = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_got.delete(); m_n = 0; m_words = 0;
    end else begin
      chk("byte_ready", bus.byte_ready, m_loading && !m_wr);
      chk("write_enable", bus.write_enable, m_wr);
      chk("done", bus.done, m_done);
      chk("error", bus.error, m_err);
      chk("cpu_hold", bus.cpu_hold, m_loading || m_done);
      if (m_wr) begin
        chk("write_address", bus.write_address, BASE + 32'(4 * m_words));
        chk("write_data", bus.write_data,
            {m_got[2+4*m_words], m_got[3+4*m_words], m_got[4+4*m_words], m_got[5+4*m_words]});
      end
      if (bus.write_enable) begin
        log_a.push_back(bus.write_address);
        log_d.push_back(bus.write_data);
        last_we_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_done) begin
        m_done = 0;
      end else if (m_loading) begin
        if (m_wr) begin
          m_wr = 0;
          m_words++;
          if (m_words == m_n) begin
            m_loading = 0;
            m_done    = 1;
          end
        end else if (bus.byte_valid) begin
          m_got.push_back(bus.byte_data);
          if (m_got.size() == 2) begin
            m_n = {m_got[0], m_got[1]};
            if (m_n == 0) begin
              m_loading = 0;
              m_done    = 1;
            end else if (m_n > DEPTH) begin
              m_loading = 0;
              m_err     = 1;
            end
          end else if (m_got.size() > 2 && (m_got.size() - 2) % 4 == 0) begin
            m_wr = 1;
          end
        end
      end else if (bus.start) begin
        m_loading = 1; m_err = 0;
        m_got.delete(); m_n = 0; m_words = 0;
      end
    end
  end

  logic [31:0] img[$];
  logic [31:0] save_a[$];
  logic [31:0] save_d[$];
  int          stall_pct = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    for (int s = 0; s < 3; s++) begin
      if (stall_pct == 0 || $urandom_range(99) >= stall_pct) break;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (1) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) break;
      guard++;
      if (guard > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int g = 0;
    while (1) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.error === 1'b1) break;
      g++;
      if (g > 100) begin
        chk("end_timeout", 0, 1);
        break;
      end
    end
    tick();
  endtask

  task automatic run_load(input logic [15:0] n, input bit start_mid);
    log_a.delete();
    log_d.delete();
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int w = 0; w < img.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        if (start_mid && w == 0 && k == 2) bus.start = 1'b1;
        send_byte(img[w][8*(3-k) +: 8]);
        bus.start = 1'b0;
      end
    end
    wait_end();
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, log_d.size(), img.size());
    for (int i = 0; i < img.size() && i < log_d.size(); i++) begin
      chk({name, "_addr"}, log_a[i], BASE + 32'(4 * i));
      chk({name, "_data"}, log_d[i], img[i]);
    end
  endtask

  initial begin
    int d0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    reset          = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("post_reset_addr", bus.write_address, 32'h0040_0000);
    chk("post_reset_hold", bus.cpu_hold, 0);
    tick();

    // Nominal two-word load
    img = '{32'h2008_0005, 32'h2109_FFFF};
    d0 = done_cnt;
    run_load(16'h0002, 0);
    chk("nom_count", log_d.size(), 2);
    chk("nom_a0", log_a[0], 32'h0040_0000);
    chk("nom_d0", log_d[0], 32'h2008_0005);
    chk("nom_a1", log_a[1], 32'h0040_0004);
    chk("nom_d1", log_d[1], 32'h2109_FFFF);
    chk("nom_done_cnt", done_cnt - d0, 1);
    chk("nom_done_after_write", done_cyc - last_we_cyc, 1);
    chk("nom_hold_after_done", bus.cpu_hold, 0);

    // Empty header
    img.delete();
    d0 = done_cnt;
    run_load(16'h0000, 0);
    chk("n0_writes", log_d.size(), 0);
    chk("n0_done_cnt", done_cnt - d0, 1);

    // Oversize header, then recovery with a valid load
    run_load(16'h0021, 0);
    chk("over_error", bus.error, 1);
    chk("over_hold", bus.cpu_hold, 0);
    chk("over_ready", bus.byte_ready, 0);
    chk("over_writes", log_d.size(), 0);
    repeat (3) tick();
    rand_img(2);
    run_load(16'h0002, 0);
    chk("recover_error", bus.error, 0);
    chk_log("recover");

    // Stalled versus unstalled stream
    rand_img(3);
    stall_pct = 0;
    run_load(16'h0003, 0);
    save_a = log_a;
    save_d = log_d;
    stall_pct = 50;
    run_load(16'h0003, 0);
    stall_pct = 0;
    chk("stall_count", log_d.size(), save_d.size());
    for (int i = 0; i < 3 && i < log_d.size() && i < save_d.size(); i++) begin
      chk("stall_addr", log_a[i], save_a[i]);
      chk("stall_data", log_d[i], save_d[i]);
    end
    chk_log("stall");

    // Reset in the middle of word 1
    rand_img(2);
    log_a.delete();
    log_d.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(img[0][31:24]);
    send_byte(img[0][23:16]);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", bus.byte_ready, 0);
    chk("mid_rst_we", bus.write_enable, 0);
    chk("mid_rst_addr", bus.write_address, 32'h0040_0000);
    chk("mid_rst_data", bus.write_data, 0);
    chk("mid_rst_hold", bus.cpu_hold, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_error", bus.error, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_writes", log_d.size(), 0);
    rand_img(1);
    run_load(16'h0001, 0);
    chk("after_rst_a0", log_a[0], 32'h0040_0000);
    chk_log("after_rst");

    // Start pulsed during data collection
    rand_img(2);
    run_load(16'h0002, 1);
    chk_log("start_mid");

    // Largest legal image
    rand_img(DEPTH);
    stall_pct = 20;
    run_load(16'(DEPTH), 0);
    stall_pct = 0;
    chk_log("max");
    chk("max_last_addr", log_a[DEPTH-1], 32'h0040_007C);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
